sysid_read_arbiter: RTL



---
 rtl/sysid_arb_pkg.sv | 23 ++
 rtl/sysid_read_arbiter_if.sv | 29 ++
 rtl/sysid_rr_arbiter.sv | 28 ++
 rtl/sysid_read_arbiter.sv | 80 ++++++++
 4 files changed

// File: rtl/sysid_arb_pkg.sv
// Shared types and constants for arbiters that front the system-ID slave.
package sysid_arb_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID        = 1'b0;
  localparam logic SYSID_ADDR_TIMESTAMP = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_t;

  function automatic logic [SYSID_DATA_W-1:0] expected_word(
    input logic                    addr,
    input logic [SYSID_DATA_W-1:0] id,
    input logic [SYSID_DATA_W-1:0] timestamp
  );
    return (addr == SYSID_ADDR_TIMESTAMP) ? timestamp : id;
  endfunction

endpackage

// File: rtl/sysid_read_arbiter_if.sv
// Requester-side Avalon-MM read bus, one bit per requester on the control lines.
interface sysid_read_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  import sysid_arb_pkg::*;

  logic [NUM_REQ-1:0]      req_read;
  logic [NUM_REQ-1:0]      req_address;
  logic [NUM_REQ-1:0]      req_waitrequest;
  logic [SYSID_DATA_W-1:0] req_readdata;
  logic [NUM_REQ-1:0]      req_readdatavalid;

  modport master (
    output req_read,
    output req_address,
    input  req_waitrequest,
    input  req_readdata,
    input  req_readdatavalid
  );

  modport slave (
    input  req_read,
    input  req_address,
    output req_waitrequest,
    output req_readdata,
    output req_readdatavalid
  );

endinterface

// File: rtl/sysid_rr_arbiter.sv
// Rotating-priority pick: first asserted request at or after the pointer, wrapping.
module sysid_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IDX_W-1:0]   pointer,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int unsigned idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(pointer) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && request[idx[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sysid_read_arbiter.sv
// Round-robin read arbiter sharing one system-ID slave between NUM_REQ masters,
// with a sticky check of returned words against the expected ID/timestamp.
module sysid_read_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int unsigned             NUM_REQ            = 2,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'h56D5E87F
) (
  input  logic                    clock,
  input  logic                    reset,
  sysid_read_arbiter_if.slave     req_bus,
  output logic                    sysid_address,
  input  logic [SYSID_DATA_W-1:0] sysid_readdata,
  output logic                    busy,
  output logic                    id_mismatch
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic [NUM_REQ-1:0] accept;

  sysid_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .request   (req_bus.req_read),
    .pointer   (rr_ptr),
    .winner    (winner),
    .any_valid (any_req)
  );

  always_comb begin
    accept = '0;
    if (state == IDLE && any_req) accept[winner] = 1'b1;
    req_bus.req_waitrequest = reset ? '1 : (req_bus.req_read & ~accept);
  end

  // sysid_address doubles as the latched request address, so it only moves on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                     <= IDLE;
      rr_ptr                    <= '0;
      grant                     <= '0;
      sysid_address             <= SYSID_ADDR_ID;
      req_bus.req_readdata      <= '0;
      req_bus.req_readdatavalid <= '0;
      busy                      <= 1'b0;
      id_mismatch               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant         <= winner;
            sysid_address <= req_bus.req_address[winner];
            busy          <= 1'b1;
            state         <= READ;
          end
        end
        READ: begin
          req_bus.req_readdata             <= sysid_readdata;
          req_bus.req_readdatavalid[grant] <= 1'b1;
          if (sysid_readdata != expected_word(sysid_address, EXPECTED_ID, EXPECTED_TIMESTAMP))
            id_mismatch <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          req_bus.req_readdatavalid <= '0;
          busy                      <= 1'b0;
          rr_ptr                    <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state                     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
